// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 16x oversampling 8N1 UART receiver; define UART_RX_PARITY_EN for an even parity bit after D7
module uart_rx_sampler #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int OSR    = 16,
  parameter int DIV    = CLK_HZ / (BAUD * OSR)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int            CW        = $clog2(DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [3:0]    SMP_LAST  = 4'(OSR - 1);
  localparam logic [3:0]    SMP_MID   = 4'(OSR / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s, rx_d;
  logic          fall, tick, at_mid, at_end;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    smp_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          done_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic          perr_nxt;
`endif

  // rx_d is the edge-detect history flop behind the 2-FF synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign tick   = (tick_cnt == TICK_LAST);
  assign at_mid = tick && (smp_cnt == SMP_MID);
  assign at_end = tick && (smp_cnt == SMP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fall) state_next = S_START;
      S_START: if (at_mid) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (at_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (at_end) state_next = S_STOP;
`endif
      S_STOP:  if (at_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Framing error outranks parity error so a frame raises at most one pulse
  always_comb begin
    o_busy   = (state != S_IDLE);
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt = 1'b0;
`endif
    if (state == S_STOP && at_end) begin
      if (!rx_s)
        ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (par_bad)
        perr_nxt = 1'b1;
`endif
      else
        done_nxt = 1'b1;
    end
  end

  // Holding the tick counter at zero in IDLE puts the first tick DIV clocks after the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      smp_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if (state == S_IDLE || tick) tick_cnt <= '0;
      else                         tick_cnt <= tick_cnt + 1'b1;

      if (state == S_IDLE || (state == S_START && at_mid)) smp_cnt <= '0;
      else if (tick)                                       smp_cnt <= smp_cnt + 1'b1;

      if (state == S_IDLE)                 bit_idx <= '0;
      else if (state == S_DATA && at_end)  bit_idx <= bit_idx + 1'b1;

      if (state == S_DATA && at_end) shreg <= {rx_s, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            par_bad <= 1'b0;
    else if (state == S_IDLE)             par_bad <= 1'b0;
    else if (state == S_PARITY && at_end) par_bad <= rx_s ^ (^shreg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_parity_err <= 1'b0;
    else       o_parity_err <= perr_nxt;
  end
`else
  assign par_bad      = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rx_data   <= 8'h00;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done   <= done_nxt && !par_bad;
      o_frame_err <= ferr_nxt;
      if (done_nxt && !par_bad) o_rx_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - scoreboard bench for uart_rx_sampler at DIV=10 (160 clk per bit)
module tb_uart_rx_sampler;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BUSY_EXP  = BIT_CLK / 2 + (FRAME_BITS - 1) * BIT_CLK;
  localparam int FRAME_CLK = FRAME_BITS * BIT_CLK;

  localparam logic [1:0] K_DONE  = 2'd0;
  localparam logic [1:0] K_FRAME = 2'd1;
  localparam logic [1:0] K_PAR   = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done, o_frame_err, o_parity_err, o_busy;

  uart_rx_sampler #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .o_rx_data    (o_rx_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    logic [1:0] exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] mon_k;
  vec_t       vecs[7];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cyc_prev = 0;
  int done_cyc_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every output pulse is matched against the oldest expected event
  always @(negedge clk) begin
    if (o_busy) busy_cnt++;
    if (!reset && (o_rx_done || o_frame_err || o_parity_err)) begin
      chk("pulse_onehot", 32'($countones({o_rx_done, o_frame_err, o_parity_err})), 32'd1);
      mon_k = o_frame_err ? K_FRAME : (o_parity_err ? K_PAR : K_DONE);
      if (o_rx_done) begin
        done_cyc_prev = done_cyc_last;
        done_cyc_last = cyc;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: kind %0d data 0x%0h, no event expected", mon_k, o_rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
        chk("rx_data", 32'(o_rx_data), 32'(mon_e.data));
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, bclk);
`else
    if (par_flip) rx = 1'b1;
`endif
    drive_bit(stop, bclk);
    rx = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{8'h63, 1'b0, 160, K_FRAME, 8'h72};
    vecs[1] = '{8'h00, 1'b1, 160, K_DONE,  8'h00};
    vecs[2] = '{8'hFF, 1'b1, 160, K_DONE,  8'hFF};
    vecs[3] = '{8'hA5, 1'b0, 160, K_FRAME, 8'hFF};
    vecs[4] = '{8'h3C, 1'b1, 157, K_DONE,  8'h3C};
    vecs[5] = '{8'hC3, 1'b1, 163, K_DONE,  8'hC3};
    vecs[6] = '{8'h81, 1'b1, 160, K_DONE,  8'h81};

    repeat (3) @(negedge clk);
    chk("reset_data", 32'(o_rx_data), 32'h00);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_pulses", 32'({o_rx_done, o_frame_err, o_parity_err}), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    busy_cnt = 0;
    exp_q.push_back('{K_DONE, 8'h72});
    send_frame(8'h72, 1'b1, 1'b0, BIT_CLK);
    drain(100);
    repeat (20) @(negedge clk);
    chk("busy_len_ok", 32'(busy_cnt >= BUSY_EXP - 4 && busy_cnt <= BUSY_EXP + 4), 32'd1);
    chk("busy_idle", 32'(o_busy), 32'd0);

    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy", 32'(o_busy), 32'd1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_idle", 32'(o_busy), 32'd0);
    chk("glitch_data", 32'(o_rx_data), 32'h72);

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{vecs[i].exp_kind, vecs[i].exp_data});
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, vecs[i].bclk);
      drain(100);
      repeat (100) @(negedge clk);
    end

    exp_q.push_back('{K_DONE, 8'h72});
    exp_q.push_back('{K_DONE, 8'h73});
    send_frame(8'h72, 1'b1, 1'b0, BIT_CLK);
    send_frame(8'h73, 1'b1, 1'b0, BIT_CLK);
    drain(100);
    chk("b2b_gap_ok", 32'((done_cyc_last - done_cyc_prev) >= FRAME_CLK - 2 &&
                          (done_cyc_last - done_cyc_prev) <= FRAME_CLK + 2), 32'd1);
    chk("b2b_data", 32'(o_rx_data), 32'h73);
    repeat (100) @(negedge clk);

    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b0, BIT_CLK);
    drive_bit(1'b1, BIT_CLK / 2);
    chk("mid_frame_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_data", 32'(o_rx_data), 32'h00);
    chk("midreset_busy", 32'(o_busy), 32'd0);
    chk("midreset_pulses", 32'({o_rx_done, o_frame_err, o_parity_err}), 32'd0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_reset_idle", 32'(o_busy), 32'd0);
    exp_q.push_back('{K_DONE, 8'h55});
    send_frame(8'h55, 1'b1, 1'b0, BIT_CLK);
    drain(100);
    repeat (100) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back('{K_DONE, 8'h72});
    send_frame(8'h72, 1'b1, 1'b0, BIT_CLK);
    drain(100);
    repeat (100) @(negedge clk);
    exp_q.push_back('{K_PAR, 8'h72});
    send_frame(8'hF0, 1'b1, 1'b1, BIT_CLK);
    drain(100);
    repeat (100) @(negedge clk);
    exp_q.push_back('{K_FRAME, 8'h72});
    send_frame(8'h0F, 1'b0, 1'b1, BIT_CLK);
    drain(100);
    repeat (100) @(negedge clk);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
